sdram_mport_arbiter: RTL and testbench

- Parametrised multi-channel successor to the single write/single read FIFO-to-SDRAM control path.
- Serves N_CH independent channels. Each channel is a write (FIFO to SDRAM) or read (SDRAM to FIFO) channel, selected by the CH_DIR bit.
- Per channel it generates wrapping burst addresses and arbitrates round-robin onto the single sdram_ctrl request port. It steers the per-word ack to the granted channel's FIFO enable.
- Sits between the per-channel FIFOs and sdram_ctrl, in the sys_clk (100 MHz) domain. FIFO levels arrive already synchronised.

---
 rtl/sdram_mport_arbiter.sv | 113 +++++++++++
 tb/tb_sdram_mport_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_mport_arbiter.sv
// sdram_mport_arbiter: round-robin arbiter steering N_CH FIFO channels onto one sdram_ctrl burst port
module sdram_mport_arbiter #(
  parameter int N_CH = 4,
  parameter int AW = 24,
  parameter int LW = 10,
  parameter logic [N_CH-1:0] CH_DIR = 4'b0011
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_end,
  input  logic              read_valid,
  input  logic [N_CH-1:0]   ch_rst,
  input  logic [N_CH*AW-1:0] ch_b_addr,
  input  logic [N_CH*AW-1:0] ch_e_addr,
  input  logic [N_CH*LW-1:0] ch_burst_len,
  input  logic [N_CH*LW-1:0] ch_level,
  output logic [N_CH-1:0]   ch_fifo_en,
  output logic [N_CH-1:0]   grant,
  output logic              sdram_wr_req,
  output logic              sdram_rd_req,
  output logic [AW-1:0]     sdram_addr_o,
  output logic [LW-1:0]     burst_len_o,
  input  logic              sdram_wr_ack,
  input  logic              sdram_rd_ack
);
  localparam int GW = $clog2(N_CH);
  typedef enum logic [2:0] {IDLE, ARB, REQ, XFER, DONE} state_t;
  state_t          state_q;
  logic [N_CH-1:0] elig_q, pend_q, grant_q;
  logic [GW-1:0]   ptr_q, g_q, pick_d;
  logic            found_d, ack_g, wr_req_q, rd_req_q, start_q;
  logic [AW-1:0]   addr_q [N_CH];
  logic [AW-1:0]   addr_o_q, inc_d, lim_d, b_g, next_addr_d;
  logic [LW-1:0]   len_o_q;

  assign ack_g        = CH_DIR[g_q] ? sdram_wr_ack : sdram_rd_ack;
  assign ch_fifo_en   = grant_q & ((CH_DIR & {N_CH{sdram_wr_ack}}) | (~CH_DIR & {N_CH{sdram_rd_ack}}));
  assign grant        = grant_q;
  assign sdram_wr_req = wr_req_q;
  assign sdram_rd_req = rd_req_q;
  assign sdram_addr_o = addr_o_q;
  assign burst_len_o  = len_o_q;
  // A final partial burst is never issued: wrap once the following burst would pass e_addr.
  assign b_g          = ch_b_addr[g_q*AW +: AW];
  assign inc_d        = addr_o_q + AW'(len_o_q);
  assign lim_d        = ch_e_addr[g_q*AW +: AW] - AW'(len_o_q);
  assign next_addr_d  = (pend_q[g_q] || ch_rst[g_q] || inc_d > lim_d) ? b_g : inc_d;

  // Descending scan so the lowest offset from the pointer wins.
  always_comb begin
    pick_d  = '0;
    found_d = 1'b0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (elig_q[(int'(ptr_q) + k) % N_CH]) begin
        pick_d  = GW'((int'(ptr_q) + k) % N_CH);
        found_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      elig_q   <= '0;
      pend_q   <= '0;
      grant_q  <= '0;
      ptr_q    <= '0;
      g_q      <= '0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      start_q  <= 1'b0;
      addr_o_q <= '0;
      len_o_q  <= '0;
      for (int i = 0; i < N_CH; i++) addr_q[i] <= '0;
    end else begin
      start_q <= 1'b1;
      for (int i = 0; i < N_CH; i++) begin
        elig_q[i] <= init_end && (CH_DIR[i] || read_valid) && !ch_rst[i] &&
                     (ch_level[i*LW +: LW] >= ch_burst_len[i*LW +: LW]);
        if (!start_q || ch_rst[i]) addr_q[i] <= ch_b_addr[i*AW +: AW];
        if (ch_rst[i] && grant_q[i]) pend_q[i] <= 1'b1;
      end
      case (state_q)
        IDLE: if (|elig_q) state_q <= ARB;
        ARB: begin
          state_q <= found_d ? REQ : IDLE;
          if (found_d) begin
            g_q      <= pick_d;
            grant_q  <= N_CH'(1) << pick_d;
            addr_o_q <= addr_q[pick_d];
            len_o_q  <= ch_burst_len[pick_d*LW +: LW];
            wr_req_q <= CH_DIR[pick_d];
            rd_req_q <= !CH_DIR[pick_d];
          end
        end
        REQ: if (ack_g) begin
          wr_req_q <= 1'b0;
          rd_req_q <= 1'b0;
          state_q  <= XFER;
        end
        XFER: if (!ack_g) state_q <= DONE;
        DONE: begin
          addr_q[g_q] <= next_addr_d;
          pend_q[g_q] <= 1'b0;
          ptr_q       <= (g_q == GW'(N_CH - 1)) ? '0 : g_q + 1'b1;
          grant_q     <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_mport_arbiter.sv
// tb_sdram_mport_arbiter: bench acting as sdram_ctrl, checked against a burst-level round-robin model
module tb_sdram_mport_arbiter;
  localparam int N = 4, AW = 24, LW = 10;
  localparam logic [N-1:0] DIR = 4'b0011;

  logic clk = 1'b0, rst_n = 1'b0, init_end = 1'b0, read_valid = 1'b0;
  logic wr_ack = 1'b0, rd_ack = 1'b0;
  logic [N-1:0] ch_rst = '0;
  logic [AW-1:0] b [N], e [N];
  logic [LW-1:0] lvl [N], blen [N];
  logic [N*AW-1:0] b_p, e_p;
  logic [N*LW-1:0] len_p, lvl_p;
  logic [N-1:0] fifo_en, grant;
  logic wr_req, rd_req;
  logic [AW-1:0] addr;
  logic [LW-1:0] len;

  logic [AW-1:0] m_addr [N];
  int m_ptr = 0, n_chk = 0, n_fail = 0;
  logic [AW-1:0] last_addr;
  logic [N-1:0] last_grant;
  logic last_rd;
  logic [AW-1:0] exp_wrap [5];
  logic [N-1:0] exp_rot [5];

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign b_p[i*AW +: AW]   = b[i];
    assign e_p[i*AW +: AW]   = e[i];
    assign len_p[i*LW +: LW] = blen[i];
    assign lvl_p[i*LW +: LW] = lvl[i];
  end

  sdram_mport_arbiter #(.N_CH(N), .AW(AW), .LW(LW), .CH_DIR(DIR)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .init_end(init_end), .read_valid(read_valid),
    .ch_rst(ch_rst), .ch_b_addr(b_p), .ch_e_addr(e_p), .ch_burst_len(len_p), .ch_level(lvl_p),
    .ch_fifo_en(fifo_en), .grant(grant), .sdram_wr_req(wr_req), .sdram_rd_req(rd_req),
    .sdram_addr_o(addr), .burst_len_o(len), .sdram_wr_ack(wr_ack), .sdram_rd_ack(rd_ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic bit m_elig(input int i);
    return init_end && (DIR[i] || read_valid) && (lvl[i] >= blen[i]);
  endfunction

  task automatic m_reset();
    m_ptr = 0;
    for (int i = 0; i < N; i++) m_addr[i] = b[i];
  endtask

  task automatic apply_cfg();
    ch_rst = '1;
    @(negedge clk);
    ch_rst = '0;
    for (int i = 0; i < N; i++) m_addr[i] = b[i];
  endtask

  task automatic serve(input bit stop, input bit rst_mid);
    int t, g;
    bit found;
    logic [AW-1:0] a, l;
    t = 0;
    while (!(wr_req || rd_req) && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("req_seen", 64'(wr_req | rd_req), 64'(1));
    if (!(wr_req || rd_req)) return;
    found = 1'b0;
    g = 0;
    for (int k = N - 1; k >= 0; k--)
      if (m_elig((m_ptr + k) % N)) begin
        g = (m_ptr + k) % N;
        found = 1'b1;
      end
    chk("model_elig", 64'(found), 64'(1));
    chk("grant", 64'(grant), 64'(4'b1 << g));
    chk("addr", 64'(addr), 64'(m_addr[g]));
    chk("burst_len", 64'(len), 64'(blen[g]));
    chk("wr_req", 64'(wr_req), 64'(DIR[g]));
    chk("rd_req", 64'(rd_req), 64'(!DIR[g]));
    last_addr = addr;
    last_grant = grant;
    last_rd = rd_req;
    repeat ($urandom_range(0, 2)) begin
      if (DIR[g]) rd_ack = 1'($urandom); else wr_ack = 1'($urandom);
      #1 chk("wrong_ack_en", 64'(fifo_en), 64'(0));
      @(negedge clk);
      chk("req_hold", 64'(wr_req | rd_req), 64'(1));
    end
    wr_ack = 1'b0;
    rd_ack = 1'b0;
    for (int k = 0; k < int'(blen[g]); k++) begin
      if (DIR[g]) wr_ack = 1'b1; else rd_ack = 1'b1;
      ch_rst[g] = rst_mid && k == 1;
      #1 chk("fifo_en", 64'(fifo_en), 64'(4'b1 << g));
      @(negedge clk);
      if (k == 0) chk("req_drop", 64'(wr_req | rd_req), 64'(0));
    end
    wr_ack = 1'b0;
    rd_ack = 1'b0;
    ch_rst = '0;
    if (stop) for (int i = 0; i < N; i++) lvl[i] = '0;
    a = m_addr[g];
    l = AW'(blen[g]);
    m_addr[g] = (rst_mid || a + l > e[g] - l) ? b[g] : a + l;
    m_ptr = (g + 1) % N;
    @(negedge clk);
    @(negedge clk);
    chk("grant_clear", 64'(grant), 64'(0));
    if (stop) begin
      repeat (4) @(negedge clk);
      chk("quiet", 64'(wr_req | rd_req | (|grant)), 64'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_wrap = '{24'd0, 24'd8, 24'd16, 24'd24, 24'd0};
    exp_rot  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < N; i++) begin
      b[i] = '0; e[i] = '0; lvl[i] = '0; blen[i] = LW'(1);
    end
    b[0] = 24'd0; e[0] = 24'd64; blen[0] = 10'd8; lvl[0] = 10'd16;
    repeat (3) @(negedge clk);
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_req", 64'({wr_req, rd_req}), 64'(0));
    chk("rst_addr", 64'(addr), 64'(0));
    chk("rst_len", 64'(len), 64'(0));
    chk("rst_fifo_en", 64'(fifo_en), 64'(0));
    rst_n = 1'b1;
    m_reset();
    repeat (5) @(negedge clk);
    chk("no_req_pre_init", 64'(wr_req | rd_req), 64'(0));
    init_end = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("lat_early", 64'(wr_req), 64'(0));
    @(negedge clk);
    chk("lat_req", 64'(wr_req), 64'(1));
    serve(1'b0, 1'b0);
    chk("first_addr", 64'(last_addr), 64'(0));
    serve(1'b1, 1'b0);
    chk("second_addr", 64'(last_addr), 64'(8));

    e[0] = 24'd32; lvl[0] = 10'd16;
    apply_cfg();
    for (int i = 0; i < 5; i++) begin
      serve(i == 4, 1'b0);
      chk("wrap_addr", 64'(last_addr), 64'(exp_wrap[i]));
    end

    b[2] = 24'd200; e[2] = 24'd400; blen[2] = 10'd8; lvl[2] = 10'd512; read_valid = 1'b0;
    apply_cfg();
    repeat (10) @(negedge clk);
    chk("rv_block", 64'(wr_req | rd_req), 64'(0));
    read_valid = 1'b1;
    serve(1'b1, 1'b0);
    chk("rv_rd", 64'(last_rd), 64'(1));
    chk("rv_grant", 64'(last_grant), 64'(4'b0100));

    b[1] = 24'd8; e[1] = 24'd200; blen[1] = 10'd16; lvl[1] = 10'd20;
    apply_cfg();
    serve(1'b0, 1'b0);
    serve(1'b0, 1'b0);
    serve(1'b0, 1'b1);
    chk("chrst_addr", 64'(last_addr), 64'(40));
    serve(1'b1, 1'b0);
    chk("chrst_reload", 64'(last_addr), 64'(8));

    b[0] = 24'd100; e[0] = 24'd300; blen[0] = 10'd4; lvl[0] = 10'd10;
    apply_cfg();
    serve(1'b0, 1'b0);
    chk("pre_rst_addr", 64'(last_addr), 64'(100));
    for (int t = 0; t < 60 && !wr_req; t++) @(negedge clk);
    chk("partial_req", 64'(wr_req), 64'(1));
    wr_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_grant", 64'(grant), 64'(0));
    chk("arst_req", 64'({wr_req, rd_req}), 64'(0));
    chk("arst_fifo_en", 64'(fifo_en), 64'(0));
    wr_ack = 1'b0;
    for (int i = 0; i < N; i++) begin
      b[i] = (i == 0) ? 24'd100 : AW'(i * 1000);
      e[i] = b[i] + 24'd500;
      blen[i] = 10'd4;
      lvl[i] = 10'd10;
    end
    read_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    for (int i = 0; i < 5; i++) begin
      serve(i == 4, 1'b0);
      chk("rotation", 64'(last_grant), 64'(exp_rot[i]));
      if (i == 0) chk("arst_restart_addr", 64'(last_addr), 64'(100));
    end

    for (int p = 0; p < 10; p++) begin
      bit any;
      int nb;
      for (int i = 0; i < N; i++) begin
        blen[i] = LW'($urandom_range(1, 12));
        lvl[i] = ($urandom % 3 != 0) ? blen[i] + LW'($urandom_range(0, 20))
                                      : LW'($urandom_range(0, int'(blen[i]) - 1));
        b[i] = AW'($urandom_range(0, 4000));
        e[i] = b[i] + AW'($urandom_range(0, 60));
      end
      read_valid = 1'($urandom);
      apply_cfg();
      any = 1'b0;
      for (int i = 0; i < N; i++) any |= m_elig(i);
      if (any) begin
        nb = $urandom_range(3, 8);
        for (int j = 0; j < nb; j++) serve(j == nb - 1, 1'b0);
      end else begin
        repeat (10) @(negedge clk);
        chk("rand_quiet", 64'(wr_req | rd_req), 64'(0));
        for (int i = 0; i < N; i++) lvl[i] = '0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
